// File: rtl/ad7265_ctrl.sv
// AD7265 dual-ADC serial controller: frames ncs/adc_sclk, scans channel
// addresses round-robin, deserialises douta/doutb and publishes one A/B
// result pair per frame together with a frame-integrity flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ncs high, sclk high, waiting for scan_en
// S_SETUP | ncs low, sclk high, T_CSS cycles before the first falling edge
// S_LOW   | sclk low half period (entered on each sclk falling edge)
// S_HIGH  | sclk high half period; after 32 falling edges leave to S_DONE
// S_DONE  | ncs high quiet time between frames
module ad7265_ctrl #(
  parameter int SCLK_HALF = 2,
  parameter int T_CSS     = 2,
  parameter int QUIET     = 4,
  parameter int NUM_CH    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        rng_sel,
  output logic        adc_sclk,
  output logic        ncs,
  output logic        rng,
  output logic [2:0]  adc_addr,
  input  logic        douta,
  input  logic        doutb,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_a,
  output logic [11:0] result_b,
  output logic        frame_err
);

  localparam int CM1  = (T_CSS > SCLK_HALF) ? T_CSS : SCLK_HALF;
  localparam int CMAX = (CM1 > QUIET) ? CM1 : QUIET;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] LD_CSS   = CW'(T_CSS - 1);
  localparam logic [CW-1:0] LD_HALF  = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] LD_QUIET = CW'(QUIET - 1);
  localparam logic [2:0]    LAST_CH  = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_DONE} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_ld;
  logic           w_tc, w_start, w_fall, w_done, w_err;
  logic [5:0]     r_edges;
  logic           r_da, r_db;
  logic [31:0]    r_sa, r_sb;
  logic           r_ncs, r_sclk, r_rng, r_valid, r_err;
  logic [2:0]     r_addr, r_ch;
  logic [11:0]    r_ra, r_rb;
  logic           w_unused;

  assign w_tc = (r_cnt == '0);

  // Bit 0 of each frame is the tri-stated tail; it is shifted in but never used.
  assign w_unused = r_sa[0] ^ r_sb[0];

  // Fixed-zero bits must be clear and each line's second word must mirror the other line's first word.
  assign w_err = (|{r_sa[31:30], r_sa[17:14], r_sa[1], r_sb[31:30], r_sb[17:14], r_sb[1]})
               | (r_sa[13:2] != r_sb[29:18])
               | (r_sb[13:2] != r_sa[29:18]);

  // Next-state logic, frame events and the timer reload value for the state being entered.
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_fall     = 1'b0;
    w_done     = 1'b0;
    w_cnt_ld   = '0;
    case (r_state)
      S_IDLE: begin
        if (scan_en) begin
          w_state_nx = S_SETUP;
          w_start    = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_tc) begin
          w_state_nx = S_LOW;
          w_fall     = 1'b1;
        end
      end
      S_LOW: begin
        if (w_tc) w_state_nx = S_HIGH;
      end
      S_HIGH: begin
        if (w_tc) begin
          if (r_edges == 6'd32) begin
            w_state_nx = S_DONE;
            w_done     = 1'b1;
          end else begin
            w_state_nx = S_LOW;
            w_fall     = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (w_tc) begin
          if (scan_en) begin
            w_state_nx = S_SETUP;
            w_start    = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    case (w_state_nx)
      S_SETUP:       w_cnt_ld = LD_CSS;
      S_LOW, S_HIGH: w_cnt_ld = LD_HALF;
      S_DONE:        w_cnt_ld = LD_QUIET;
      default:       w_cnt_ld = '0;
    endcase
  end

  // State register and per-state down-counter, reloaded on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_state_nx != r_state) r_cnt <= w_cnt_ld;
      else if (!w_tc)            r_cnt <= r_cnt - 1'b1;
    end
  end

  // Pins are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs  <= 1'b1;
      r_sclk <= 1'b1;
      r_rng  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_ncs  <= !(w_state_nx == S_SETUP || w_state_nx == S_LOW || w_state_nx == S_HIGH);
      r_sclk <= (w_state_nx != S_LOW);
      if (w_start) r_rng <= rng_sel;
      if (w_done)  r_addr <= (r_addr == LAST_CH) ? 3'd0 : r_addr + 3'd1;
    end
  end

  // Input retiming plus MSB-first deserialisation on every sclk falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_da    <= 1'b0;
      r_db    <= 1'b0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_edges <= '0;
    end else begin
      r_da <= douta;
      r_db <= doutb;
      if (w_start) r_edges <= '0;
      else if (w_fall) r_edges <= r_edges + 6'd1;
      if (w_fall) begin
        r_sa <= {r_sa[30:0], r_da};
        r_sb <= {r_sb[30:0], r_db};
      end
    end
  end

  // Publish the completed frame on the cycle ncs rises; fields hold until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_ch  <= r_addr;
        r_ra  <= r_sa[29:18];
        r_rb  <= r_sb[29:18];
        r_err <= w_err;
      end
    end
  end

  assign ncs          = r_ncs;
  assign adc_sclk     = r_sclk;
  assign rng          = r_rng;
  assign adc_addr     = r_addr;
  assign result_valid = r_valid;
  assign result_ch    = r_ch;
  assign result_a     = r_ra;
  assign result_b     = r_rb;
  assign frame_err    = r_err;

endmodule

// File: tb/tb_ad7265_ctrl.sv
// Bench for ad7265_ctrl: an AD7265 bus model drives frames built from data
// words; expected results come from those words and the injected faults.
module tb_ad7265_ctrl;
  localparam int NUM_CH = 6;

  logic        clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, rng_sel = 1'b0;
  logic        douta = 1'b0, doutb = 1'b0;
  logic        adc_sclk, ncs, rng, result_valid, frame_err;
  logic [2:0]  adc_addr, result_ch;
  logic [11:0] result_a, result_b;

  ad7265_ctrl dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .rng_sel(rng_sel),
    .adc_sclk(adc_sclk), .ncs(ncs), .rng(rng), .adc_addr(adc_addr),
    .douta(douta), .doutb(doutb), .result_valid(result_valid),
    .result_ch(result_ch), .result_a(result_a), .result_b(result_b),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int frame_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC bus model: bit 31 appears at ncs fall, each sclk fall moves to the next bit.
  logic [31:0] tb_fa = '0, tb_fb = '0, bfm_a = '0, bfm_b = '0;
  int          bidx = -1;
  logic        bfm_pncs = 1'b1, bfm_psclk = 1'b1;
  always @(ncs or adc_sclk) begin
    if (ncs === 1'b0 && bfm_pncs) begin
      bfm_a = tb_fa;
      bfm_b = tb_fb;
      bidx  = 31;
    end else if (ncs === 1'b0 && adc_sclk === 1'b0 && bfm_psclk) begin
      bidx--;
    end
    if (ncs !== 1'b0 || bidx < 0) begin
      douta = 1'b0;
      doutb = 1'b0;
    end else begin
      douta = bfm_a[bidx[4:0]];
      doutb = bfm_b[bidx[4:0]];
    end
    bfm_pncs  = ncs;
    bfm_psclk = adc_sclk;
  end

  // Bus observer: falling edges and latency per frame, pin stability while ncs is low.
  int         m_falls = 0, m_lat = 0, m_addr_chg = 0, m_rng_chg = 0, m_low_cyc = 0, m_valid_cnt = 0;
  logic       m_pncs = 1'b1, m_psclk = 1'b1, m_prng = 1'b0;
  logic [2:0] m_paddr = '0;
  always @(negedge clk) begin
    if (m_pncs && ncs === 1'b0) begin
      m_falls <= 0;
      m_lat   <= 0;
    end else begin
      m_lat <= m_lat + 1;
      if (ncs === 1'b0 && m_psclk && adc_sclk === 1'b0) m_falls <= m_falls + 1;
    end
    if (ncs === 1'b0 && !m_pncs) begin
      if (adc_addr !== m_paddr) m_addr_chg <= m_addr_chg + 1;
      if (rng !== m_prng)       m_rng_chg  <= m_rng_chg + 1;
    end
    if (ncs === 1'b0)   m_low_cyc   <= m_low_cyc + 1;
    if (result_valid)   m_valid_cnt <= m_valid_cnt + 1;
    m_pncs  <= ncs;
    m_psclk <= adc_sclk;
    m_paddr <= adc_addr;
    m_prng  <= rng;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ncs_low();
    for (int i = 0; i < 400 && ncs !== 1'b0; i++) tick();
    chk("ncs_fall_timeout", 32'(ncs), 32'd0);
  endtask

  task automatic wait_falls(input int n);
    for (int i = 0; i < 400 && m_falls < n; i++) tick();
    chk("falls_timeout", 32'(m_falls >= n), 32'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 400 && result_valid !== 1'b1; i++) tick();
    chk("valid_timeout", 32'(result_valid), 32'd1);
  endtask

  task automatic idle_check();
    int l0;
    l0 = m_low_cyc;
    repeat (40) tick();
    chk("idle_no_frame", 32'(m_low_cyc - l0), 32'd0);
    chk("idle_ncs_high", 32'(ncs), 32'd1);
  endtask

  function automatic logic [31:0] mkframe(input logic [11:0] w1, input logic [11:0] w2);
    return {2'b00, w1, 4'h0, w2, 2'b00};
  endfunction

  // kind 0: clean, 1: a fixed-zero bit set, 2: a cross-copy word corrupted.
  task automatic gen(input int kind, output logic [31:0] fa, output logic [31:0] fb,
                     output logic [11:0] a, output logic [11:0] b);
    int          zpos[7] = '{31, 30, 17, 16, 15, 14, 1};
    logic [31:0] m;
    a  = 12'($urandom);
    b  = 12'($urandom);
    fa = mkframe(a, b);
    fb = mkframe(b, a);
    fa[0] = 1'($urandom);
    fb[0] = 1'($urandom);
    m = '0;
    if (kind == 1) m = 32'd1 << zpos[$urandom_range(0, 6)];
    if (kind == 2) m = {18'd0, 12'($urandom_range(1, 4095)), 2'b00};
    if ($urandom_range(0, 1) == 0) fa = fa ^ m;
    else fb = fb ^ m;
  endtask

  task automatic run_one(input logic [31:0] fa, input logic [31:0] fb, input logic [11:0] ea,
                         input logic [11:0] eb, input logic eerr, input int drop_at);
    logic exp_rng;
    tb_fa = fa;
    tb_fb = fb;
    wait_ncs_low();
    exp_rng = rng_sel;
    if (drop_at >= 0) begin
      wait_falls(drop_at);
      scan_en = 1'b0;
    end else begin
      repeat ($urandom_range(5, 100)) tick();
      rng_sel = 1'($urandom);
    end
    wait_valid();
    chk("result_a", 32'(result_a), 32'(ea));
    chk("result_b", 32'(result_b), 32'(eb));
    chk("frame_err", 32'(frame_err), 32'(eerr));
    chk("result_ch", 32'(result_ch), 32'(frame_no % NUM_CH));
    chk("rng_frame", 32'(rng), 32'(exp_rng));
    chk("sclk_falls", 32'(m_falls), 32'd32);
    chk("valid_latency", 32'(m_lat), 32'd130);
    frame_no++;
    tick();
    chk("valid_width", 32'(result_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] fa, fb;
    logic [11:0] a, b;
    int          v0, l0;

    // Reset values, then 1000 idle cycles with scan_en low.
    repeat (3) tick();
    chk("rst_ncs", 32'(ncs), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd1);
    chk("rst_addr", 32'(adc_addr), 32'd0);
    chk("rst_rng", 32'(rng), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_result", 32'({result_ch, result_a, result_b, frame_err}), 32'd0);
    rst_n = 1'b1;
    v0 = m_valid_cnt;
    l0 = m_low_cyc;
    repeat (1000) tick();
    chk("idle_no_valid", 32'(m_valid_cnt - v0), 32'd0);
    chk("idle_no_ncs", 32'(m_low_cyc - l0), 32'd0);
    chk("idle_addr", 32'(adc_addr), 32'd0);

    // Single directed frame, scan_en dropped as soon as the frame starts.
    scan_en = 1'b1;
    run_one(mkframe(12'hABC, 12'h123), mkframe(12'h123, 12'hABC), 12'hABC, 12'h123, 1'b0, 0);
    idle_check();

    // Round-robin scan over 8 frames; the last one drops scan_en after its 10th falling edge.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    frame_no = 0;
    scan_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      gen(kind, fa, fb, a, b);
      run_one(fa, fb, a, b, kind != 0, (i == 7) ? 10 : -1);
    end
    idle_check();

    // Directed fault injection, then more random frames.
    scan_en = 1'b1;
    run_one(mkframe(12'hABC, 12'h123) | 32'h0000_8000, mkframe(12'h123, 12'hABC),
            12'hABC, 12'h123, 1'b1, -1);
    run_one(mkframe(12'hABC, 12'hABD), mkframe(12'h123, 12'hABC), 12'hABC, 12'h123, 1'b1, -1);
    run_one(mkframe(12'hABC, 12'h123), mkframe(12'h123, 12'hABC), 12'hABC, 12'h123, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      gen(kind, fa, fb, a, b);
      run_one(fa, fb, a, b, kind != 0, (i == 5) ? 5 : -1);
    end
    idle_check();

    // Reset after the 20th falling edge aborts the frame without a result.
    scan_en = 1'b1;
    tb_fa = mkframe(12'h555, 12'hAAA);
    tb_fb = mkframe(12'hAAA, 12'h555);
    wait_ncs_low();
    wait_falls(20);
    v0 = m_valid_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_ncs", 32'(ncs), 32'd1);
    chk("abort_sclk", 32'(adc_sclk), 32'd1);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_addr", 32'(adc_addr), 32'd0);
    repeat (3) tick();
    scan_en = 1'b0;
    rst_n = 1'b1;
    frame_no = 0;
    repeat (300) tick();
    chk("abort_no_valid", 32'(m_valid_cnt - v0), 32'd0);

    chk("addr_stable", 32'(m_addr_chg), 32'd0);
    chk("rng_stable", 32'(m_rng_chg), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
